// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and result signals of the ALU command sequencer.
// slave is the sequencer's view; master is the surrounding producer/ALU/consumer.
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic             alu_clr;
  logic [WIDTH-1:0] alu_res;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic [2:0]       out_sel;
  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, in_sel, alu_res, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, alu_clr, out_valid, out_res, out_sel, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_sel, alu_res, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel, alu_clr, out_valid, out_res, out_sel, busy
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a small FIFO, issues one at a time, holds operands for the
// op latency (pulsing alu_clr for the multi-cycle op) and returns the captured result.
//
//  state | meaning
//  IDLE  | waiting for a command in the FIFO
//  EXEC  | operands held on the ALU, counting down the op latency
//  DONE  | result presented on out_res until the consumer accepts it
module alu_cmd_sequencer #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 4,
  parameter int MUL_CYCLES = 34
) (
  input logic             clk,
  input logic             reset,
  alu_cmd_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MUL_CYCLES + 1);
  localparam logic [2:0] SEL_MUL = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem_a   [DEPTH];
  logic [WIDTH-1:0] mem_b   [DEPTH];
  logic [2:0]       mem_sel [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             push;
  logic             pop;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [2:0]       alu_sel_q;
  logic             alu_clr_q;
  logic [WIDTH-1:0] out_res_q;
  logic [2:0]       out_sel_q;
  logic             out_valid_q;
  logic             busy_q;

  assign full         = (count == (AW + 1)'(DEPTH));
  assign push         = bus.in_valid && !full;
  assign pop          = (state == IDLE) && (count != '0);
  assign bus.in_ready = !full;

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.alu_clr   = alu_clr_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

  // Storage needs no reset: entries are only read once count says they were written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= bus.in_a;
      mem_b[wr_ptr]   <= bus.in_b;
      mem_sel[wr_ptr] <= bus.in_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      alu_clr_q   <= 1'b0;
      out_res_q   <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            alu_a_q   <= mem_a[rd_ptr];
            alu_b_q   <= mem_b[rd_ptr];
            alu_sel_q <= mem_sel[rd_ptr];
            if (mem_sel[rd_ptr] == SEL_MUL) begin
              cnt       <= CW'(MUL_CYCLES);
              alu_clr_q <= 1'b1;
            end else begin
              cnt       <= '0;
              alu_clr_q <= 1'b0;
            end
            busy_q <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          alu_clr_q <= 1'b0;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            out_res_q   <= bus.alu_res;
            out_sel_q   <= alu_sel_q;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // Returning to IDLE first means the next pop lands one edge after the handshake.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: transaction-level timing model checked every
// cycle, plus literal expectations for the hand-computed scenarios.
module tb_alu_cmd_sequencer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int MUL   = 34;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    int          acc;
  } cmd_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MUL_CYCLES(MUL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] sel);
    case (sel)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b111:  return a * b;
      default: return a ^ b;
    endcase
  endfunction

  // Bench ALU: the product only becomes final MUL cycles after the clear pulse.
  int mc = 255;
  always @(posedge clk) begin
    if (bus.alu_clr) mc <= 0;
    else if (mc != 255) mc <= mc + 1;
  end
  always_comb begin
    if (bus.alu_sel == 3'b111 && mc < MUL - 1) bus.alu_res = 32'hDEAD_BEEF;
    else bus.alu_res = alu_f(bus.alu_a, bus.alu_b, bus.alu_sel);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state and observation log
  int          cyc = 0;
  bit          started = 0;
  cmd_t        pend[$];
  cmd_t        cur;
  bit          infl = 0;
  int          issue_e = 0, valid_e = 0, avail_e = 0;
  logic [31:0] m_res = '0, m_a = '0, m_b = '0;
  logic [2:0]  m_sel = '0, m_asel = '0;
  bit          exp_valid_prev = 0;
  bit          prev_valid = 0;
  logic [31:0] prev_res = '0;
  logic [2:0]  prev_sel = '0;
  int          acc_count = 0, last_acc = 0, rise_cyc = 0, clr_count = 0;
  logic [31:0] log_res[$];
  logic [2:0]  log_sel[$];
  int          log_rise[$];

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!reset) begin
        started = 1;
        pend.delete();
        infl = 0;
        avail_e = 0;
        m_res = '0; m_sel = '0; m_a = '0; m_b = '0; m_asel = '0;
        exp_valid_prev = 0;
      end else if (started) begin
        int occ0;
        cmd_t c;
        occ0 = pend.size();
        if (prev_valid && bus.out_ready) begin
          log_res.push_back(prev_res);
          log_sel.push_back(prev_sel);
          log_rise.push_back(rise_cyc);
        end
        if (exp_valid_prev && bus.out_ready) begin
          infl = 0;
          avail_e = cyc + 1;
        end
        if (!infl && pend.size() > 0 && cyc >= pend[0].acc + 1 && cyc >= avail_e) begin
          cur = pend.pop_front();
          infl = 1;
          issue_e = cyc;
          valid_e = cyc + ((cur.sel == 3'b111) ? MUL + 1 : 1);
          m_a = cur.a; m_b = cur.b; m_asel = cur.sel;
        end
        if (infl && cyc == valid_e) begin
          m_res = alu_f(cur.a, cur.b, cur.sel);
          m_sel = cur.sel;
        end
        if (bus.in_valid && occ0 < DEPTH) begin
          c.a = bus.in_a; c.b = bus.in_b; c.sel = bus.in_sel; c.acc = cyc;
          pend.push_back(c);
          acc_count++;
          last_acc = cyc;
        end
      end
      if (started) begin
        bit ev;
        ev = infl && (cyc >= valid_e);
        check("out_valid", 64'(bus.out_valid), 64'(ev));
        check("busy",      64'(bus.busy),      64'(infl));
        check("alu_clr",   64'(bus.alu_clr),
              64'(infl && cur.sel == 3'b111 && cyc == issue_e));
        check("in_ready",  64'(bus.in_ready),  64'(pend.size() < DEPTH));
        check("out_res",   64'(bus.out_res),   64'(m_res));
        check("out_sel",   64'(bus.out_sel),   64'(m_sel));
        check("alu_a",     64'(bus.alu_a),     64'(m_a));
        check("alu_b",     64'(bus.alu_b),     64'(m_b));
        check("alu_sel",   64'(bus.alu_sel),   64'(m_asel));
        exp_valid_prev = ev;
      end
      if (bus.out_valid === 1'b1 && !prev_valid) rise_cyc = cyc;
      if (bus.alu_clr === 1'b1) clr_count++;
      prev_valid = (bus.out_valid === 1'b1);
      prev_res   = bus.out_res;
      prev_sel   = bus.out_sel;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] sel);
    int base;
    base = acc_count;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_sel = sel;
    for (int i = 0; i < 100 && acc_count == base; i++) tick(1);
    bus.in_valid = 1'b0;
    if (acc_count == base) check("push_timeout", 64'(acc_count), 64'(base + 1));
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 300 && log_res.size() < n; i++) tick(1);
    check("result_count", 64'(log_res.size()), 64'(n));
  endtask

  initial begin
    int acc0;
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_sel = '0;
    bus.out_ready = 1'b1;

    // 1) reset
    tick(2);
    reset = 1'b1;
    tick(1);
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_alu_clr",   64'(bus.alu_clr),   64'(0));
    check("rst_busy",      64'(bus.busy),      64'(0));
    check("rst_in_ready",  64'(bus.in_ready),  64'(1));
    check("rst_out_res",   64'(bus.out_res),   64'(0));

    // 2) single-cycle add
    clr_count = 0;
    push(32'd8, 32'd4, 3'b000);
    acc0 = last_acc;
    wait_results(1);
    check("add_res",     64'(log_res[0]), 64'(12));
    check("add_sel",     64'(log_sel[0]), 64'(0));
    check("add_latency", 64'(log_rise[0] - acc0), 64'(2));
    check("add_no_clr",  64'(clr_count), 64'(0));

    // 3) multi-cycle multiply
    clr_count = 0;
    push(32'd14, 32'd5, 3'b111);
    acc0 = last_acc;
    wait_results(2);
    check("mul_res",     64'(log_res[1]), 64'(70));
    check("mul_sel",     64'(log_sel[1]), 64'(7));
    check("mul_latency", 64'(log_rise[1] - acc0), 64'(MUL + 2));
    check("mul_clr_one", 64'(clr_count), 64'(1));

    // 4) backpressure and FIFO fill
    bus.out_ready = 1'b0;
    push(32'd8, 32'd4, 3'b001);
    for (int i = 0; i < 4; i++) push(32'd3, 32'd3, 3'b000);
    tick(2);
    check("full_in_ready", 64'(bus.in_ready), 64'(0));
    for (int i = 0; i < 4; i++) begin
      check("held_res",   64'(bus.out_res),   64'(4));
      check("held_valid", 64'(bus.out_valid), 64'(1));
      tick(1);
    end

    // 5a) push while full is dropped
    acc0 = acc_count;
    bus.in_valid = 1'b1; bus.in_a = 32'd9; bus.in_b = 32'd9; bus.in_sel = 3'b000;
    tick(4);
    bus.in_valid = 1'b0;
    check("full_drop", 64'(acc_count), 64'(acc0));
    bus.out_ready = 1'b1;
    wait_results(7);
    check("seq0", 64'(log_res[2]), 64'(4));
    for (int i = 3; i < 7; i++) check("seq_n", 64'(log_res[i]), 64'(6));
    tick(20);
    check("no_dropped_result", 64'(log_res.size()), 64'(7));

    // 5b) simultaneous push and pop at count=3
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'd1, 32'd1, 3'b000);
    tick(4);
    bus.out_ready = 1'b1;
    tick(1);
    push(32'd5, 32'd5, 3'b000);
    push(32'd6, 32'd6, 3'b000);
    check("pushpop_full", 64'(bus.in_ready), 64'(0));
    wait_results(13);
    for (int i = 7; i < 11; i++) check("pp_res", 64'(log_res[i]), 64'(2));
    check("pp_res5", 64'(log_res[11]), 64'(10));
    check("pp_res6", 64'(log_res[12]), 64'(12));

    // 6) reset mid multiply
    push(32'd14, 32'd5, 3'b111);
    push(32'd1, 32'd1, 3'b000);
    tick(10);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    check("abort_busy",     64'(bus.busy),      64'(0));
    check("abort_in_ready", 64'(bus.in_ready),  64'(1));
    check("abort_valid",    64'(bus.out_valid), 64'(0));
    tick(MUL + 10);
    check("abort_no_result", 64'(log_res.size()), 64'(13));
    check("abort_idle_valid", 64'(bus.out_valid), 64'(0));
    push(32'd8, 32'd4, 3'b000);
    wait_results(14);
    check("post_reset_res", 64'(log_res[13]), 64'(12));
    tick(10);
    check("post_reset_count", 64'(log_res.size()), 64'(14));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
